cpu_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control unit for the 16-bit CPU, successor to the fixed-width control FSM. It fetches and decodes each instruction and drives the register file, ALU, flag register, PC and memory port.
- New in this generation: a memory ready/request handshake with wait states, configurable register count and address width, N selectable SNES controller channels, and a single-cycle link/button writeback path.
- It also adds a resumable halt and a defined fall-through for unknown special opcodes.

---
 rtl/cpu_ctrl_pkg.sv | 57 +++++
 rtl/cpu_cond_eval.sv | 43 ++++
 rtl/cpu_ctrl_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared constants for the multi-cycle CPU control unit.
//   - FSM state encodings (4-bit, legacy-compatible constants)
//   - instruction field codes (major opcodes, special ext codes)
//   - branch condition codes and flag bit positions in the {Z,C,F,N,L} bus
//   - writeback source encodings for wb_sel
package cpu_ctrl_pkg;

  localparam logic [3:0] ST_RESET  = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXEC_R = 4'd3;
  localparam logic [3:0] ST_LOAD   = 4'd4;
  localparam logic [3:0] ST_STORE  = 4'd5;
  localparam logic [3:0] ST_JUMP   = 4'd6;
  localparam logic [3:0] ST_JAL    = 4'd7;
  localparam logic [3:0] ST_SNES   = 4'd8;
  localparam logic [3:0] ST_HALT   = 4'd9;

  localparam logic [3:0] MAJ_RTYPE0  = 4'b0000;
  localparam logic [3:0] MAJ_SPECIAL = 4'b0100;
  localparam logic [3:0] MAJ_CMPI    = 4'b1011;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_SNES  = 4'b1111;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  localparam logic [3:0] CC_Z  = 4'h0;
  localparam logic [3:0] CC_NZ = 4'h1;
  localparam logic [3:0] CC_C  = 4'h2;
  localparam logic [3:0] CC_NC = 4'h3;
  localparam logic [3:0] CC_L  = 4'h4;
  localparam logic [3:0] CC_NL = 4'h5;
  localparam logic [3:0] CC_N  = 4'h6;
  localparam logic [3:0] CC_NN = 4'h7;
  localparam logic [3:0] CC_F  = 4'h8;
  localparam logic [3:0] CC_NF = 4'h9;
  localparam logic [3:0] CC_HI = 4'hA;
  localparam logic [3:0] CC_LS = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

endpackage

// File: rtl/cpu_cond_eval.sv
// cpu_cond_eval: combinational branch condition evaluator.
//   code  in  4  condition code from instr[11:8]
//   flags in  5  {Z,C,F,N,L}
//   taken out 1  branch taken
module cpu_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] code,
  input  logic [4:0] flags,
  output logic       taken
);

  logic z, c, f, n, l;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign f = flags[FLAG_F];
  assign n = flags[FLAG_N];
  assign l = flags[FLAG_L];

  always_comb begin
    taken = 1'b0;
    case (code)
      CC_Z:    taken = z;
      CC_NZ:   taken = !z;
      CC_C:    taken = c;
      CC_NC:   taken = !c;
      CC_L:    taken = l;
      CC_NL:   taken = !l;
      CC_N:    taken = n;
      CC_NN:   taken = !n;
      CC_F:    taken = f;
      CC_NF:   taken = !f;
      CC_HI:   taken = !l && !z;
      CC_LS:   taken = l || z;
      CC_GT:   taken = !n && !z;
      CC_LE:   taken = n || z;
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit for the 16-bit CPU.
//   clk, reset (async, active-low)
//   mem_in/mem_ready      memory read data and access-complete handshake
//   flags {Z,C,F,N,L}, pc_ins (current PC), snes_data (12 bits per channel)
//   resume                leave HALT
//   opcode, reg_en, mux_A_sel, mux_B_sel, wb_sel, link_data  datapath control
//   pc_sel, mem_req, mem_w_en                                 memory port
//   flag_en, pc_en, pc_ld, halted                             misc enables
//
// state  | meaning
// RESET  | first cycle after reset release
// FETCH  | read instruction at PC, wait for mem_ready
// DECODE | PC increment, pick execute state
// EXEC_R | ALU op, writeback from ALU, flags updated
// LOAD   | read memory at reg A, write rdest when mem_ready
// STORE  | write reg B to memory at reg A, wait for mem_ready
// JUMP   | conditional PC load from reg A
// JAL    | link PC into rdest, PC load from reg A
// SNES   | controller button word into rdest
// HALT   | idle until resume
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 16,
  parameter int NUM_SNES   = 2,
  parameter int RSEL_W     = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            mem_in,
  input  logic                   mem_ready,
  input  logic [4:0]             flags,
  input  logic [ADDR_WIDTH-1:0]  pc_ins,
  input  logic [12*NUM_SNES-1:0] snes_data,
  input  logic                   resume,
  output logic [15:0]            opcode,
  output logic [NUM_REGS-1:0]    reg_en,
  output logic [RSEL_W-1:0]      mux_A_sel,
  output logic [RSEL_W-1:0]      mux_B_sel,
  output logic [1:0]             wb_sel,
  output logic [15:0]            link_data,
  output logic                   pc_sel,
  output logic                   mem_req,
  output logic                   mem_w_en,
  output logic                   flag_en,
  output logic                   pc_en,
  output logic                   pc_ld,
  output logic                   halted
);

  logic [3:0]          state, state_d;
  logic [15:0]         instr, instr_d;
  logic [15:0]         opcode_d, link_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic [RSEL_W-1:0]   a_d, b_d;
  logic [1:0]          wb_d;
  logic                pc_sel_d, mem_req_d, mem_w_en_d, flag_en_d, pc_en_d, pc_ld_d, halted_d;
  logic                taken, is_cmp, load_wait;
  logic [11:0]         snes_word;

  // Indices at or above NUM_REGS select nothing.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (idx == k[3:0]) v[k] = 1'b1;
    return v;
  endfunction

  cpu_cond_eval u_cond (
    .code  (instr[11:8]),
    .flags (flags),
    .taken (taken)
  );

  assign is_cmp = (instr[15:12] == MAJ_CMPI) ||
                  ((instr[15:12] == MAJ_RTYPE0) && (instr[7:4] == EXT_CMP));

  always_comb begin
    snes_word = '0;
    for (int k = 0; k < NUM_SNES; k++)
      if (instr[3:0] == k[3:0]) snes_word = snes_data[12*k +: 12];
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (instr == 16'h0000)                state_d = ST_HALT;
        else if (instr[15:12] != MAJ_SPECIAL) state_d = ST_EXEC_R;
        else begin
          case (instr[7:4])
            EXT_LOAD:  state_d = ST_LOAD;
            EXT_STORE: state_d = ST_STORE;
            EXT_JAL:   state_d = ST_JAL;
            EXT_JCOND: state_d = ST_JUMP;
            EXT_SNES:  state_d = ST_SNES;
            default:   state_d = ST_FETCH;   // unknown special: NOP
          endcase
        end
      end
      ST_LOAD, ST_STORE: if (mem_ready) state_d = ST_FETCH;
      ST_HALT:           if (resume)    state_d = ST_FETCH;
      default:           state_d = ST_FETCH;
    endcase
  end

  assign instr_d = (state == ST_FETCH && mem_ready) ? mem_in : instr;

  // Outputs are a function of the next state so that they are registered
  // alongside it and valid for the whole state cycle.
  always_comb begin
    opcode_d   = '0;
    reg_en_d   = '0;
    a_d        = '0;
    b_d        = '0;
    wb_d       = WB_ALU;
    link_d     = '0;
    pc_sel_d   = 1'b1;
    mem_req_d  = 1'b0;
    mem_w_en_d = 1'b0;
    flag_en_d  = 1'b0;
    pc_en_d    = 1'b0;
    pc_ld_d    = 1'b0;
    halted_d   = 1'b0;
    case (state_d)
      ST_FETCH:  mem_req_d = 1'b1;
      ST_DECODE: pc_en_d = 1'b1;
      ST_EXEC_R: begin
        opcode_d  = instr;
        a_d       = instr[8 +: RSEL_W];
        b_d       = instr[0 +: RSEL_W];
        flag_en_d = 1'b1;
        if (!is_cmp) reg_en_d = onehot(instr[11:8]);
      end
      ST_LOAD: begin
        mem_req_d = 1'b1;
        pc_sel_d  = 1'b0;
        a_d       = instr[0 +: RSEL_W];
        wb_d      = WB_MEM;
        reg_en_d  = onehot(instr[11:8]);
      end
      ST_STORE: begin
        mem_req_d  = 1'b1;
        mem_w_en_d = 1'b1;
        pc_sel_d   = 1'b0;
        a_d        = instr[0 +: RSEL_W];
        b_d        = instr[8 +: RSEL_W];
      end
      ST_JUMP: begin
        a_d     = instr[0 +: RSEL_W];
        pc_ld_d = taken;
        pc_en_d = taken;
      end
      ST_JAL: begin
        link_d   = 16'(pc_ins);
        wb_d     = WB_LINK;
        reg_en_d = onehot(instr[11:8]);
        pc_ld_d  = 1'b1;
        pc_en_d  = 1'b1;
        a_d      = instr[0 +: RSEL_W];
      end
      ST_SNES: begin
        link_d   = {4'b0, snes_word};
        wb_d     = WB_LINK;
        reg_en_d = onehot(instr[11:8]);
      end
      ST_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RESET;
      instr     <= '0;
      opcode    <= '0;
      reg_en_q  <= '0;
      mux_A_sel <= '0;
      mux_B_sel <= '0;
      wb_sel    <= WB_ALU;
      link_data <= '0;
      pc_sel    <= 1'b1;
      mem_req   <= 1'b0;
      mem_w_en  <= 1'b0;
      flag_en   <= 1'b0;
      pc_en     <= 1'b0;
      pc_ld     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      instr     <= instr_d;
      opcode    <= opcode_d;
      reg_en_q  <= reg_en_d;
      mux_A_sel <= a_d;
      mux_B_sel <= b_d;
      wb_sel    <= wb_d;
      link_data <= link_d;
      pc_sel    <= pc_sel_d;
      mem_req   <= mem_req_d;
      mem_w_en  <= mem_w_en_d;
      flag_en   <= flag_en_d;
      pc_en     <= pc_en_d;
      pc_ld     <= pc_ld_d;
      halted    <= halted_d;
    end
  end

  // The load data is only valid in the cycle memory reports ready, so the
  // registered write enable is masked during LOAD wait states.
  assign load_wait = (state == ST_LOAD) && !mem_ready;
  assign reg_en    = reg_en_q & ~{NUM_REGS{load_wait}};

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
`timescale 1ns/1ps
module tb_cpu_ctrl_fsm;

  localparam int AW = 12;
  localparam int NR = 8;
  localparam int NS = 2;
  localparam int RW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [15:0]    mem_in = '0;
  logic           mem_ready = 1'b1;
  logic [4:0]     flags = '0;
  logic [AW-1:0]  pc_ins = '0;
  logic [12*NS-1:0] snes_data = '0;
  logic           resume = 1'b0;
  logic [15:0]    opcode, link_data;
  logic [NR-1:0]  reg_en;
  logic [RW-1:0]  mux_A_sel, mux_B_sel;
  logic [1:0]     wb_sel;
  logic           pc_sel, mem_req, mem_w_en, flag_en, pc_en, pc_ld, halted;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_SNES(NS)) dut (
    .clk(clk), .reset(reset), .mem_in(mem_in), .mem_ready(mem_ready),
    .flags(flags), .pc_ins(pc_ins), .snes_data(snes_data), .resume(resume),
    .opcode(opcode), .reg_en(reg_en), .mux_A_sel(mux_A_sel), .mux_B_sel(mux_B_sel),
    .wb_sel(wb_sel), .link_data(link_data), .pc_sel(pc_sel), .mem_req(mem_req),
    .mem_w_en(mem_w_en), .flag_en(flag_en), .pc_en(pc_en), .pc_ld(pc_ld), .halted(halted)
  );

  typedef struct {
    logic [15:0]   opcode;
    logic [NR-1:0] reg_en;
    logic [RW-1:0] a, b;
    logic [1:0]    wb;
    logic [15:0]   link;
    logic          pc_sel, mem_req, mem_w_en, flag_en, pc_en, pc_ld, halted;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_model(input logic [3:0] code, input logic [4:0] f);
    logic z, c, fl, n, l, t;
    z = f[4]; c = f[3]; fl = f[2]; n = f[1]; l = f[0];
    case (code)
      4'h0: t = z;          4'h1: t = !z;
      4'h2: t = c;          4'h3: t = !c;
      4'h4: t = l;          4'h5: t = !l;
      4'h6: t = n;          4'h7: t = !n;
      4'h8: t = fl;         4'h9: t = !fl;
      4'hA: t = !l && !z;   4'hB: t = l || z;
      4'hC: t = !n && !z;   4'hD: t = n || z;
      4'hE: t = 1'b1;       default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic exp_t model(input logic [15:0] ins, input logic [4:0] f,
                                 input logic [AW-1:0] pc, input logic [12*NS-1:0] sn);
    exp_t e;
    logic [3:0] maj, rd, ex, rs;
    logic [NR-1:0] one, rd_oh;
    logic [191:0] big;
    maj = ins[15:12]; rd = ins[11:8]; ex = ins[7:4]; rs = ins[3:0];
    one = 1;
    rd_oh = (rd < NR) ? (one << rd) : '0;
    big = 192'(sn);
    e.opcode = '0; e.reg_en = '0; e.a = '0; e.b = '0; e.wb = 2'b00; e.link = '0;
    e.pc_sel = 1'b1; e.mem_req = 1'b0; e.mem_w_en = 1'b0; e.flag_en = 1'b0;
    e.pc_en = 1'b0; e.pc_ld = 1'b0; e.halted = 1'b0;
    if (ins == 16'h0000) e.halted = 1'b1;
    else if (maj != 4'h4) begin
      e.opcode = ins; e.a = rd[RW-1:0]; e.b = rs[RW-1:0]; e.flag_en = 1'b1;
      e.reg_en = (maj == 4'hB || (maj == 4'h0 && ex == 4'hB)) ? '0 : rd_oh;
    end else begin
      case (ex)
        4'h0: begin e.mem_req = 1; e.pc_sel = 0; e.a = rs[RW-1:0]; e.wb = 2'b01; e.reg_en = rd_oh; end
        4'h4: begin e.mem_req = 1; e.mem_w_en = 1; e.pc_sel = 0; e.a = rs[RW-1:0]; e.b = rd[RW-1:0]; end
        4'h8: begin e.link = {4'h0, pc}; e.wb = 2'b10; e.reg_en = rd_oh; e.pc_ld = 1; e.pc_en = 1; e.a = rs[RW-1:0]; end
        4'hC: begin e.a = rs[RW-1:0]; e.pc_ld = cond_model(rd, f); e.pc_en = e.pc_ld; end
        4'hF: begin e.link = (rs < NS) ? {4'h0, big[12*rs +: 12]} : 16'h0; e.wb = 2'b10; e.reg_en = rd_oh; end
        default: e.mem_req = 1'b1;   // NOP: back in FETCH
      endcase
    end
    return e;
  endfunction

  // 0: single exec cycle, 1: memory access, 2: NOP, 3: HALT
  function automatic int kind_of(input logic [15:0] ins);
    int k;
    if (ins == 16'h0000) k = 3;
    else if (ins[15:12] != 4'h4) k = 0;
    else begin
      case (ins[7:4])
        4'h0, 4'h4:       k = 1;
        4'h8, 4'hC, 4'hF: k = 0;
        default:          k = 2;
      endcase
    end
    return k;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq($sformatf("%s.sb_empty", tag), 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check_eq($sformatf("%s.opcode", tag),   64'(opcode),    64'(e.opcode));
    check_eq($sformatf("%s.reg_en", tag),   64'(reg_en),    64'(e.reg_en));
    check_eq($sformatf("%s.A", tag),        64'(mux_A_sel), 64'(e.a));
    check_eq($sformatf("%s.B", tag),        64'(mux_B_sel), 64'(e.b));
    check_eq($sformatf("%s.wb_sel", tag),   64'(wb_sel),    64'(e.wb));
    check_eq($sformatf("%s.link", tag),     64'(link_data), 64'(e.link));
    check_eq($sformatf("%s.ctl", tag),
             64'({pc_sel, mem_req, mem_w_en, flag_en, pc_en, pc_ld, halted}),
             64'({e.pc_sel, e.mem_req, e.mem_w_en, e.flag_en, e.pc_en, e.pc_ld, e.halted}));
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at a negedge in FETCH.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input string tag);
    int k;
    k = kind_of(ins);
    check_eq($sformatf("%s.fetch", tag), 64'({mem_req, pc_sel, mem_w_en, pc_en}), 64'(4'b1100));
    mem_in = ins;
    sb.push_back(model(ins, flags, pc_ins, snes_data));
    mem_ready = (fw == 0);
    for (int w = 0; w < fw; w++) begin
      @(negedge clk);
      check_eq($sformatf("%s.fetch_hold", tag), 64'({mem_req, pc_sel, pc_en}), 64'(3'b110));
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check_eq($sformatf("%s.decode", tag), 64'({pc_en, pc_ld, mem_req, flag_en}), 64'(4'b1000));
    mem_in = 16'hDEAD;
    if (k == 1 && mw > 0) mem_ready = 1'b0;
    @(negedge clk);
    if (k == 1) begin
      for (int w = 0; w < mw; w++) begin
        #1;
        check_eq($sformatf("%s.mem_hold", tag),
                 64'({mem_req, pc_sel, reg_en == '0, mux_A_sel}),
                 64'({1'b1, 1'b0, 1'b1, ins[RW-1:0]}));
        @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      compare_pop(tag);
      @(negedge clk);
    end else if (k == 2) begin
      compare_pop(tag);
    end else if (k == 3) begin
      compare_pop(tag);
      repeat (3) begin
        @(negedge clk);
        check_eq($sformatf("%s.halt_hold", tag), 64'({halted, mem_req}), 64'(2'b10));
      end
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
    end else begin
      compare_pop(tag);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_vals",
             {opcode, reg_en, mux_A_sel, mux_B_sel, wb_sel, link_data,
              pc_sel, mem_req, mem_w_en, flag_en, pc_en, pc_ld, halted},
             {16'h0, 8'h0, 3'd0, 3'd0, 2'b00, 16'h0, 7'b1000000});
    reset = 1'b1;
    @(negedge clk);

    run_instr(16'h1203, 0, 0, "rtype");
    run_instr(16'h01B3, 1, 0, "cmp");
    run_instr(16'hB512, 0, 0, "cmpi");
    run_instr(16'h1A03, 0, 0, "rdest_trunc");
    run_instr(16'h4302, 0, 2, "load_wait");
    run_instr(16'h4106, 0, 0, "load_fast");
    run_instr(16'h4541, 1, 1, "store");
    pc_ins = 12'h0A5;
    run_instr(16'h4783, 0, 0, "jal");
    snes_data = {12'hABC, 12'h123};
    run_instr(16'h42F1, 0, 0, "snes_ch1");
    run_instr(16'h45F0, 0, 0, "snes_ch0");
    run_instr(16'h42F3, 0, 0, "snes_oob");
    run_instr(16'h4312, 0, 0, "nop_ext");
    run_instr(16'h0000, 0, 0, "halt");
    resume = 1'b1;
    run_instr(16'h2345, 0, 0, "resume_ign");
    resume = 1'b0;

    for (int p = 0; p < 6; p++) begin
      case (p)
        0: flags = 5'b00000;
        1: flags = 5'b11111;
        2: flags = 5'b10101;
        3: flags = 5'b01010;
        4: flags = 5'b00001;
        default: flags = 5'($urandom_range(0, 31));
      endcase
      for (int c = 0; c < 16; c++) begin
        logic [3:0] cc;
        cc = 4'(c);
        run_instr({4'h4, cc, 4'hC, 4'h5}, 0, 0, $sformatf("jcond_%0h_f%02h", cc, flags));
      end
    end

    // Reset asserted while FETCH is waiting on memory.
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("fetch_wait_req", 64'({mem_req, pc_sel}), 64'(2'b11));
    #2 reset = 1'b0;
    #1;
    check_eq("async_reset_vals",
             {opcode, reg_en, mux_A_sel, mux_B_sel, wb_sel, link_data,
              pc_sel, mem_req, mem_w_en, flag_en, pc_en, pc_ld, halted},
             {16'h0, 8'h0, 3'd0, 3'd0, 2'b00, 16'h0, 7'b1000000});
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    run_instr(16'h3456, 0, 0, "after_reset");

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
